// File: rtl/fifo_pkg.sv
// Shared payload type, idle value and pointer-width helper for the typed FIFO family.
package fifo_pkg;

  typedef struct packed {
    logic x;
    int   y;
    time  z;
  } payload_t;

  localparam payload_t PAYLOAD_IDLE = '{x: 1'b1, y: 7, z: 10};

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for typed_fifo; knows nothing about the payload.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic                         out_ready,
  output logic                         wr_en,
  output logic [ptr_w(DEPTH)-1:0]      wr_ptr,
  output logic [ptr_w(DEPTH)-1:0]      rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_ptr_ctrl: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_ptr_ctrl: AF_LEVEL must lie in 1..DEPTH");
  end

  logic push;
  logic pop;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign push        = in_valid & ~full;
  assign pop         = out_ready & ~empty;
  // A flushed push must not land in storage either, so the write is masked too.
  assign wr_en       = push & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/typed_fifo.sv
// First-word-fall-through FIFO carrying an arbitrary packed payload type T.
module typed_fifo
  import fifo_pkg::*;
#(
  parameter type T        = fifo_pkg::payload_t,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter T    IDLE_VAL = fifo_pkg::PAYLOAD_IDLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  T                           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output T                           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PW = ptr_w(DEPTH);

  logic          wr_en;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;

  // Handshake: a beat moves when valid & ready on that side at a rising edge;
  // in_ready is !full only, so a pop never frees a slot for a same-cycle push.
  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .wr_en       (wr_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  T mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem[rd_ptr] : IDLE_VAL;

endmodule

// File: tb/tb_typed_fifo.sv
// Directed bench for typed_fifo: default struct instance plus an int-typed DEPTH=4 instance.
module tb_typed_fifo;
  import fifo_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  payload_t   in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  payload_t   out_data;
  logic [3:0] count;
  logic       almost_full;

  // int-typed instance
  logic       i_flush = 1'b0;
  logic       i_in_valid = 1'b0;
  logic       i_in_ready;
  int         i_in_data = 0;
  logic       i_out_valid;
  logic       i_out_ready = 1'b0;
  int         i_out_data;
  logic [2:0] i_count;
  logic       i_almost_full;

  typed_fifo u_dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .count (count), .almost_full (almost_full)
  );

  typed_fifo #(.T(int), .DEPTH(4), .AF_LEVEL(3), .IDLE_VAL(-1)) u_dut_int (
    .clk (clk), .rst_n (rst_n), .flush (i_flush),
    .in_valid (i_in_valid), .in_ready (i_in_ready), .in_data (i_in_data),
    .out_valid (i_out_valid), .out_ready (i_out_ready), .out_data (i_out_data),
    .count (i_count), .almost_full (i_almost_full)
  );

  // scoreboard
  logic [96:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  localparam payload_t IDLE_EXP = '{x: 1'b1, y: 7, z: 10};

  function automatic payload_t mk(input int v);
    payload_t p;
    p.x = v[0];
    p.y = v;
    p.z = 64'(v * 3 + 100);
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int v);
    in_valid = 1'b1;
    in_data  = mk(v);
    exp_q.push_back(mk(v));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 128'(out_valid), 128'(1));
      check({tag, "_data"}, 128'(out_data), 128'(exp_q.pop_front()));
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_empty_count"}, 128'(count), 128'(0));
    check({tag, "_idle"}, 128'(out_data), 128'(IDLE_EXP));
  endtask

  initial begin
    // reset and idle
    #12;
    check("rst_count", 128'(count), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_af", 128'(almost_full), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(IDLE_EXP));
    rst_n = 1'b1;
    tick();
    check("idle_count", 128'(count), 128'(0));
    check("idle_out_data", 128'(out_data), 128'(IDLE_EXP));

    // fill to full, almost_full from count 6
    for (int i = 0; i < 8; i++) begin
      push_word(i);
      check("fill_count", 128'(count), 128'(i + 1));
      check("fill_af", 128'(almost_full), 128'((i + 1) >= 6));
    end
    check("full_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b1;
    in_data  = mk(99);
    tick();
    in_valid = 1'b0;
    check("ninth_held_count", 128'(count), 128'(8));
    drain_check("drain");

    // streaming through wrap
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = mk(200 + k);
      tick();
      check("stream_count", 128'(count), 128'(1));
      check("stream_data", 128'(out_data), 128'(mk(200 + k)));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_end_count", 128'(count), 128'(0));

    // full with push and pop in the same cycle
    for (int i = 0; i < 8; i++) push_word(300 + i);
    void'(exp_q.pop_front());
    in_valid  = 1'b1;
    in_data   = mk(400);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pushpop_count", 128'(count), 128'(7));
    tick();
    in_valid = 1'b0;
    exp_q.push_back(mk(400));
    check("full_retry_count", 128'(count), 128'(8));
    drain_check("full_drain");

    // flush with a simultaneous push at count 5
    for (int i = 0; i < 5; i++) push_word(500 + i);
    check("pre_flush_count", 128'(count), 128'(5));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(600);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_count", 128'(count), 128'(0));
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_idle", 128'(out_data), 128'(IDLE_EXP));
    push_word(700);
    check("post_flush_count", 128'(count), 128'(1));
    drain_check("post_flush");

    // asynchronous reset mid-burst at count 4
    for (int i = 0; i < 4; i++) push_word(800 + i);
    check("pre_rst_count", 128'(count), 128'(4));
    in_valid = 1'b1;
    in_data  = mk(900);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 128'(count), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_af", 128'(almost_full), 128'(0));
    check("mid_rst_out_data", 128'(out_data), 128'(IDLE_EXP));
    #4 rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(mk(900));
    tick();
    in_valid = 1'b0;
    check("resume_count", 128'(count), 128'(1));
    drain_check("resume");

    // int-typed override instance
    check("int_idle_data", 128'(i_out_data), 128'(-1));
    check("int_idle_ready", 128'(i_in_ready), 128'(1));
    for (int i = 0; i < 4; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = (i + 1) * 10;
      tick();
      check("int_fill_count", 128'(i_count), 128'(i + 1));
      check("int_fill_af", 128'(i_almost_full), 128'((i + 1) >= 3));
    end
    i_in_data = 77;
    tick();
    i_in_valid = 1'b0;
    check("int_full_ready", 128'(i_in_ready), 128'(0));
    check("int_full_count", 128'(i_count), 128'(4));
    i_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("int_drain_data", 128'(i_out_data), 128'((i + 1) * 10));
      tick();
    end
    i_out_ready = 1'b0;
    check("int_empty_data", 128'(i_out_data), 128'(-1));
    check("int_empty_valid", 128'(i_out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
